// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared segment patterns, scan-state enum and BCD decoder
//                for the four-digit seven-segment scan controller.
//                Segment order is {g,f,e,d,c,b,a}, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Non-BCD codes show a dash so corrupted upstream data is visible.
    function automatic logic [6:0] decode_bcd(input logic [3:0] nibble, input logic blank);
        logic [6:0] pat;
        if (blank) begin
            pat = SEG_BLANK;
        end else if (nibble > 4'd9) begin
            pat = SEG_DASH;
        end else begin
            pat = SEG_DIGIT[nibble];
        end
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_refresh_timer
//  Description : Digit-slot timebase. Counts REFRESH_DIV cycles per slot,
//                steps the digit index each slot and flags slot/frame ends.
//                guard_next_o tells whether the coming cycle is inside the
//                anode-off guard interval so the scan FSM stays aligned to
//                the counter. Optional SEG_SCAN_DIM_EN adds brightness_i and
//                a dim cut-off flag; without it dim_off_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_refresh_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0] brightness_i,
`endif
    output logic [1:0] idx_o,
    output logic       tick_o,
    output logic       frame_end_o,
    output logic       guard_next_o,
    output logic       dim_off_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    assign tick_o      = (cnt_q == CW'(REFRESH_DIV - 1));
    assign frame_end_o = tick_o && (idx_q == 2'd3);
    assign idx_o       = idx_q;

    // Next slot count and digit index; index wraps naturally at 3.
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        idx_d = tick_o ? idx_q + 2'd1 : idx_q;
    end

    assign guard_next_o = (int'(cnt_d) < GUARD_CYCLES);

`ifdef SEG_SCAN_DIM_EN
    // On-time fraction is (brightness+1)/8 of the slot, measured from slot start.
    assign dim_off_o = (int'(cnt_q) * 8) >= ((int'(brightness_i) + 1) * REFRESH_DIV);
`else
    assign dim_off_o = 1'b0;
`endif

    // Slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for a 4-digit common-anode
//                seven-segment display. Digits are double-buffered behind a
//                load strobe and committed only at frame end (no tearing);
//                each slot starts with a guard interval with all anodes off.
//                Optional macro SEG_SCAN_DIM_EN adds brightness[2:0] PWM.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [3:0] dig3,
    input  logic [3:0] dig2,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       blank_lz,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0] brightness,
`endif
    output logic       load_ack,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic [1:0] idx;
    logic       tick, frame_end, guard_next, dim_off;

    seg7_refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
`ifdef SEG_SCAN_DIM_EN
        .brightness_i (brightness),
`endif
        .idx_o        (idx),
        .tick_o       (tick),
        .frame_end_o  (frame_end),
        .guard_next_o (guard_next),
        .dim_off_o    (dim_off)
    );

    // Index 3 holds the leftmost digit.
    logic [3:0][3:0] disp_q, disp_d;
    logic [3:0][3:0] pend_q, pend_d;
    logic            pflag_q, pflag_d;
    logic            ack_q, ack_d;
    logic [3:0]      lz_blank;

    scan_state_t     state_q;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;

    // Leading-zero blanking ripples from the left; the rightmost digit always shows.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = blank_lz && (disp_q[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (disp_q[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (disp_q[1] == 4'd0);
    end

    // Double buffer: a strobe at frame end bypasses the pending stage.
    always_comb begin
        disp_d  = disp_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        ack_d   = 1'b0;
        if (frame_end) begin
            if (load_req) begin
                disp_d  = {dig3, dig2, dig1, dig0};
                pflag_d = 1'b0;
                ack_d   = 1'b1;
            end else if (pflag_q) begin
                disp_d  = pend_q;
                pflag_d = 1'b0;
                ack_d   = 1'b1;
            end
        end else if (load_req) begin
            pend_d  = {dig3, dig2, dig1, dig0};
            pflag_d = 1'b1;
        end
    end

    // Buffer registers and acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q  <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            ack_q   <= ack_d;
        end
    end

    // Scan FSM with registered anode and segment drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GUARD;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            case (state_q)
                GUARD: begin
                    if (!guard_next) begin
                        state_q <= ON;
                    end
                end
                ON: begin
                    if (!dim_off) begin
                        an_q  <= ~(4'b0001 << idx);
                        seg_q <= decode_bcd(disp_q[idx], lz_blank[idx]);
                    end
                    if (tick && guard_next) begin
                        state_q <= GUARD;
                    end
                end
                default: state_q <= GUARD;
            endcase
        end
    end

    assign load_ack = ack_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl with REFRESH_DIV=8,
//                GUARD_CYCLES=2. A cycle-position reference model predicts
//                anode, segment and acknowledge values every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_req = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] dig3 = 4'd0, dig2 = 4'd0, dig1 = 4'd0, dig0 = 4'd0;
    logic       load_ack;
    logic [3:0] an;
    logic [6:0] seg;
`ifdef SEG_SCAN_DIM_EN
    logic [2:0] brightness = 3'd7;
`endif

    seg7_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GRD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0),
        .blank_lz (blank_lz),
`ifdef SEG_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .load_ack (load_ack),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    // Reference model state: cycles since reset release and digit buffers.
    int         m_k;
    int         m_disp [4];
    int         m_pend [4];
    bit         m_pflag;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ack;
    int         total = 0;
    int         bad   = 0;

    function automatic logic [6:0] ref_pattern(int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // A digit is a leading zero when it and everything to its left is zero.
    function automatic bit ref_blank(int pos);
        if (!blank_lz || pos == 0) return 1'b0;
        for (int j = 3; j >= pos; j--) begin
            if (m_disp[j] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_digs(input int d3, input int d2, input int d1, input int d0);
        dig3 = 4'(d3); dig2 = 4'(d2); dig1 = 4'(d1); dig0 = 4'(d0);
    endtask

    task automatic model_clear();
        m_k = 0;
        m_pflag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_disp[i] = 0;
            m_pend[i] = 0;
        end
    endtask

    // Predict the outputs produced by the coming edge, then advance one cycle.
    task automatic step(input bit lr);
        int p;
        int slot;
        load_req = lr;
        p = m_k;
        slot = (p / DIV) % 4;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        if (p % DIV >= GRD) begin
            e_an[slot] = 1'b0;
            e_seg = ref_blank(slot) ? 7'b1111111 : ref_pattern(m_disp[slot]);
        end
        e_ack = 1'b0;
        if (p % FRAME == FRAME - 1) begin
            if (lr) begin
                m_disp[3] = int'(dig3); m_disp[2] = int'(dig2);
                m_disp[1] = int'(dig1); m_disp[0] = int'(dig0);
                m_pflag = 1'b0;
                e_ack = 1'b1;
            end else if (m_pflag) begin
                m_disp = m_pend;
                m_pflag = 1'b0;
                e_ack = 1'b1;
            end
        end else if (lr) begin
            m_pend[3] = int'(dig3); m_pend[2] = int'(dig2);
            m_pend[1] = int'(dig1); m_pend[0] = int'(dig0);
            m_pflag = 1'b1;
        end
        @(posedge clk);
        #1;
        load_req = 1'b0;
        m_k++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=%b", an, 4'b1111); end
        total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg got=%b want=%b", seg, 7'b1111111); end
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", load_ack); end
    endtask

    task automatic test_scan();
        int lowcnt [4];
        int segerr;
        segerr = 0;
        for (int i = 0; i < 4; i++) lowcnt[i] = 0;
        blank_lz = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL scan p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            for (int j = 0; j < 4; j++) if (an[j] === 1'b0) lowcnt[j]++;
            if (an !== 4'b1111 && seg !== ((an === 4'b1110) ? 7'b1000000 : 7'b1111111)) segerr++;
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (lowcnt[j] != DIV - GRD) begin
                bad++;
                $display("FAIL scan_ontime digit=%0d got=%0d want=%0d", j, lowcnt[j], DIV - GRD);
            end
        end
        total++;
        if (segerr != 0) begin bad++; $display("FAIL scan_lz_zero got=%0d bad cycles want=0", segerr); end
    endtask

    task automatic test_load_midframe();
        int acks;
        bit seen3, early;
        acks = 0; seen3 = 0; early = 0;
        blank_lz = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 10) set_digs(0, 0, 3, 1);
            step(i == 10);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL load_mid p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (load_ack === 1'b1) acks++;
            if (an === 4'b1101 && seg === 7'b0110000) begin
                if (acks == 0) early = 1'b1;
                else seen3 = 1'b1;
            end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL load_mid_acks got=%0d want=1", acks); end
        total++; if (!seen3) begin bad++; $display("FAIL load_mid_shows3 got=0 want=1"); end
        total++; if (early) begin bad++; $display("FAIL load_mid_tear got=1 want=0"); end
    endtask

    task automatic test_back_to_back();
        int a, acks;
        bit seen2, seen5;
        acks = 0; seen2 = 0; seen5 = 0;
        a = (5 - (m_k % FRAME) + FRAME) % FRAME;
        for (int i = 0; i < a + 3 * FRAME; i++) begin
            if (i == a) set_digs(0, 0, 1, 2);
            if (i == a + 15) set_digs(0, 0, 2, 5);
            step(i == a || i == a + 15);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL b2b p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (load_ack === 1'b1) acks++;
            if (acks > 0 && an === 4'b1101 && seg === 7'b0100100) seen2 = 1'b1;
            if (acks > 0 && an === 4'b1110 && seg === 7'b0010010) seen5 = 1'b1;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL b2b_acks got=%0d want=1", acks); end
        total++; if (!(seen2 && seen5)) begin bad++; $display("FAIL b2b_shows25 got=%b%b want=11", seen2, seen5); end
    endtask

    task automatic test_frame_end_load();
        int a, acks;
        bit ack_now;
        acks = 0; ack_now = 0;
        a = (FRAME - 1 - (m_k % FRAME) + FRAME) % FRAME;
        for (int i = 0; i < a + 2 * FRAME + 4; i++) begin
            if (i == a) set_digs(0, 0, 4, 2);
            step(i == a);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL fe_load p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (i == a) ack_now = load_ack;
            if (load_ack === 1'b1) acks++;
        end
        total++; if (ack_now !== 1'b1) begin bad++; $display("FAIL fe_load_ack_next got=%b want=1", ack_now); end
        total++; if (acks != 1) begin bad++; $display("FAIL fe_load_acks got=%0d want=1", acks); end
    endtask

    task automatic test_dash_and_noblank();
        bit seen_dash, seen_lead0, seen7;
        seen_dash = 0; seen_lead0 = 0; seen7 = 0;
        blank_lz = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 3) set_digs(0, 0, 0, 12);
            step(i == 3);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL dash p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (m_disp[0] == 12 && an === 4'b1110 && seg === 7'b0111111) seen_dash = 1'b1;
        end
        total++; if (!seen_dash) begin bad++; $display("FAIL dash_shown got=0 want=1"); end
        blank_lz = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 3) set_digs(0, 0, 0, 7);
            step(i == 3);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL noblank p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (m_disp[0] == 7 && an === 4'b0111 && seg === 7'b1000000) seen_lead0 = 1'b1;
            if (m_disp[0] == 7 && an === 4'b1110 && seg === 7'b1111000) seen7 = 1'b1;
        end
        total++; if (!(seen_lead0 && seen7)) begin bad++; $display("FAIL noblank_0007 got=%b%b want=11", seen_lead0, seen7); end
    endtask

    task automatic test_random();
        bit lr;
        for (int i = 0; i < 12 * FRAME; i++) begin
            lr = ($urandom_range(0, 11) == 0);
            if (lr) set_digs($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step(lr);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL random p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int a, acks;
        bit seen0;
        acks = 0; seen0 = 0;
        blank_lz = 1'b0;
        a = (2 - (m_k % FRAME) + FRAME) % FRAME;
        set_digs(9, 9, 9, 9);
        for (int i = 0; i <= a + 18; i++) begin
            step(i == a);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL rst_mid_pre p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
        end
        total++; if (an !== 4'b1011) begin bad++; $display("FAIL rst_mid_digit2_on got=%b want=1011", an); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL rst_mid_an got=%b want=1111", an); end
        total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL rst_mid_seg got=%b want=1111111", seg); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0);
            total++;
            if ({an, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++;
                $display("FAIL rst_mid_post p=%0d got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                         m_k - 1, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (load_ack === 1'b1) acks++;
            if (an === 4'b1011 && seg === 7'b1000000) seen0 = 1'b1;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL rst_mid_noack got=%0d want=0", acks); end
        total++; if (!seen0) begin bad++; $display("FAIL rst_mid_disp_zero got=0 want=1"); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_scan();
        test_load_midframe();
        test_back_to_back();
        test_frame_end_load();
        test_dash_and_noblank();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
